stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_stack_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a single-port stack core (IDLE/ISSUE/WAIT/RESP).
// Optional WAIT-state timeout abort is enabled by defining STACK_ARB_TIMEOUT_EN.
module stack_arbiter #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              op_a,
  input  logic              op_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              err_a,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_done,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_op, w_op_nxt;
  logic              r_prio_b, w_prio_b_nxt;
  logic              r_ack_a, w_ack_a_nxt;
  logic              r_ack_b, w_ack_b_nxt;
  logic              r_err_a, w_err_a_nxt;
  logic              r_err_b, w_err_b_nxt;
  logic              r_push, w_push_nxt;
  logic              r_pop, w_pop_nxt;
  logic              r_busy, w_busy_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [DATA_W-1:0] r_stk_wdata, w_stk_wdata_nxt;

  logic              w_win;
  logic              w_win_op;
  logic              w_win_reject;
  logic [DATA_W-1:0] w_win_data;

`ifdef STACK_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             w_wait_expired;
  assign w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Winner selection: a lone requester wins, contention goes to the side not served last.
  always_comb begin
    if (req_a && req_b) begin
      w_win = r_prio_b;
    end else if (req_b) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
    w_win_op     = w_win ? op_b : op_a;
    w_win_data   = w_win ? wdata_b : wdata_a;
    w_win_reject = w_win_op ? stk_full : stk_empty;
  end

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_op_nxt        = r_op;
    w_prio_b_nxt    = r_prio_b;
    w_rdata_nxt     = r_rdata;
    w_stk_wdata_nxt = r_stk_wdata;
    w_push_nxt      = 1'b0;
    w_pop_nxt       = 1'b0;
    w_ack_a_nxt     = 1'b0;
    w_ack_b_nxt     = 1'b0;
    w_err_a_nxt     = 1'b0;
    w_err_b_nxt     = 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
    w_wait_cnt_nxt  = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_a || req_b) begin
          w_owner_nxt = w_win;
          w_op_nxt    = w_win_op;
          // Full/empty is checked up front so a doomed command never reaches the core.
          if (w_win_reject) begin
            w_state_nxt = S_RESP;
            w_ack_a_nxt = ~w_win;
            w_ack_b_nxt = w_win;
            w_err_a_nxt = ~w_win;
            w_err_b_nxt = w_win;
          end else begin
            w_state_nxt     = S_ISSUE;
            w_push_nxt      = w_win_op;
            w_pop_nxt       = ~w_win_op;
            w_stk_wdata_nxt = w_win_data;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef STACK_ARB_TIMEOUT_EN
        w_wait_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        if (stk_done) begin
          w_state_nxt = S_RESP;
          w_ack_a_nxt = ~r_owner;
          w_ack_b_nxt = r_owner;
          if (!r_op) begin
            w_rdata_nxt = stk_rdata;
          end else begin
            w_rdata_nxt = r_rdata;
          end
        end
`ifdef STACK_ARB_TIMEOUT_EN
        else if (w_wait_expired) begin
          w_state_nxt = S_RESP;
          w_ack_a_nxt = ~r_owner;
          w_ack_b_nxt = r_owner;
          w_err_a_nxt = ~r_owner;
          w_err_b_nxt = r_owner;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
`else
        else begin
          w_state_nxt = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        w_state_nxt  = S_IDLE;
        w_prio_b_nxt = ~r_owner;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs; reset drops any transaction in flight without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_op        <= 1'b0;
      r_prio_b    <= 1'b0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_err_a     <= 1'b0;
      r_err_b     <= 1'b0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_busy      <= 1'b0;
      r_rdata     <= '0;
      r_stk_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_op        <= w_op_nxt;
      r_prio_b    <= w_prio_b_nxt;
      r_ack_a     <= w_ack_a_nxt;
      r_ack_b     <= w_ack_b_nxt;
      r_err_a     <= w_err_a_nxt;
      r_err_b     <= w_err_b_nxt;
      r_push      <= w_push_nxt;
      r_pop       <= w_pop_nxt;
      r_busy      <= w_busy_nxt;
      r_rdata     <= w_rdata_nxt;
      r_stk_wdata <= w_stk_wdata_nxt;
    end
  end

`ifdef STACK_ARB_TIMEOUT_EN
  // WAIT-state cycle counter, cleared on the way into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end
`endif

  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign err_a     = r_err_a;
  assign err_b     = r_err_b;
  assign rdata     = r_rdata;
  assign stk_push  = r_push;
  assign stk_pop   = r_pop;
  assign stk_wdata = r_stk_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

  stack_arbiter_checker u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack_a    (r_ack_a),
    .ack_b    (r_ack_b),
    .stk_push (r_push),
    .stk_pop  (r_pop),
    .busy     (r_busy)
  );

endmodule

// Protocol properties of the arbiter outputs, kept apart from the datapath.
module stack_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic ack_a,
  input logic ack_b,
  input logic stk_push,
  input logic stk_pop,
  input logic busy
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(stk_push && stk_pop));
  a_ack_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(ack_a && ack_b));
  a_ack_busy:    assert property (@(posedge clk) disable iff (!rst_n) (ack_a || ack_b) |-> busy);
  a_strobe_one:  assert property (@(posedge clk) disable iff (!rst_n)
                                  (stk_push || stk_pop) |=> !(stk_push || stk_pop));

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a transaction-age reference model and a stack responder.
module tb_stack_arbiter;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk, rst_n;
  logic          req_a, req_b, op_a, op_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b, err_a, err_b;
  logic [DW-1:0] rdata;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata, stk_rdata;
  logic          stk_done, stk_empty, stk_full;
  logic          busy, owner;

  int n_checks = 0;
  int n_fail   = 0;

  stack_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .rdata(rdata), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_done(stk_done),
    .stk_empty(stk_empty), .stk_full(stk_full), .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks one transaction by its age in cycles since acceptance.
  bit            m_active, m_owner, m_op, m_err, m_prio_b;
  int            m_age, m_ack_age;
  logic [DW-1:0] m_rdata, m_wdata;

  task automatic model_reset();
    m_active = 1'b0; m_owner = 1'b0; m_op = 1'b0; m_err = 1'b0; m_prio_b = 1'b0;
    m_age = 0; m_ack_age = -1; m_rdata = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (req_a || req_b) begin
        m_owner   = (req_a && req_b) ? m_prio_b : req_b;
        m_op      = m_owner ? op_b : op_a;
        m_wdata   = m_owner ? wdata_b : wdata_a;
        m_err     = m_op ? stk_full : stk_empty;
        m_active  = 1'b1;
        m_age     = 0;
        m_ack_age = m_err ? 0 : -1;
      end
    end else begin
      m_age++;
      if (m_ack_age >= 0) begin
        m_active = 1'b0;
        m_prio_b = !m_owner;
      end else if (m_age >= 2 && stk_done) begin
        m_ack_age = m_age;
        if (!m_op) m_rdata = stk_rdata;
      end
`ifdef STACK_ARB_TIMEOUT_EN
      else if (m_age == TO + 1) begin
        m_ack_age = m_age;
        m_err     = 1'b1;
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: DUT outputs against the model every falling edge.
  initial begin : cmp
    bit ea, eb, ep, eq;
    forever begin
      @(negedge clk);
      ea = m_active && (m_age == m_ack_age) && !m_owner;
      eb = m_active && (m_age == m_ack_age) && m_owner;
      ep = m_active && (m_age == 0) && !m_err && m_op;
      eq = m_active && (m_age == 0) && !m_err && !m_op;
      chk("busy", busy, m_active);
      chk("ack_a", ack_a, ea);
      chk("ack_b", ack_b, eb);
      if (ea) chk("err_a", err_a, m_err);
      if (eb) chk("err_b", err_b, m_err);
      chk("stk_push", stk_push, ep);
      chk("stk_pop", stk_pop, eq);
      if (ep || eq) chk("stk_wdata", stk_wdata, m_wdata);
      if (m_active) chk("owner", owner, m_owner);
      chk("rdata", rdata, m_rdata);
      chk("strobe_excl", stk_push && stk_pop, 1'b0);
    end
  end

  // Stack core stand-in: done one cycle after a strobe, LIFO contents in a queue.
  logic [DW-1:0] stk_q[$];
  bit resp_en, force_done, r_seen;
  initial begin
    r_seen = 1'b0; stk_done = 1'b0; stk_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) r_seen = 1'b0;
      stk_done = (resp_en && r_seen) || force_done;
      r_seen   = stk_push || stk_pop;
      if (stk_push) stk_q.push_back(stk_wdata);
      if (stk_pop) stk_rdata = (stk_q.size() > 0) ? stk_q.pop_back() : 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int max, output bit who);
    int k;
    k = 0;
    while (!(ack_a || ack_b) && k < max) begin
      tick(1);
      k++;
    end
    chk("ack_within_bound", ack_a || ack_b, 1'b1);
    who = ack_b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit who;
    req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
    wdata_a = '0; wdata_b = '0; stk_empty = 1'b0; stk_full = 1'b0;
    resp_en = 1'b1; force_done = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_outs", {stk_push, stk_pop, ack_a, ack_b, err_a, err_b}, 6'b0);
    rst_n = 1'b1;
    tick(1);

    // Single push of 0x5A from A, request dropped mid-operation.
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h5A;
    tick(1);
    chk("t1_push", stk_push, 1'b1);
    chk("t1_wdata", stk_wdata, 8'h5A);
    req_a = 1'b0;
    tick(1);
    chk("t1_push_one_cycle", stk_push, 1'b0);
    tick(1);
    chk("t1_ack_a", ack_a, 1'b1);
    chk("t1_err_a", err_a, 1'b0);
    chk("t1_ack_b", ack_b, 1'b0);
    tick(1);
    chk("t1_ack_gone", ack_a, 1'b0);

    // Pop from B returns 0x5A.
    req_b = 1'b1; op_b = 1'b0;
    tick(1);
    chk("t2_pop", stk_pop, 1'b1);
    tick(2);
    chk("t2_ack_b", ack_b, 1'b1);
    chk("t2_rdata", rdata, 8'h5A);
    chk("t2_err_b", err_b, 1'b0);
    req_b = 1'b0;
    tick(2);

    // Stray stk_done while idle is ignored.
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(1);
    chk("stray_done_busy", busy, 1'b0);

    // Contention from reset: service order A,B,A,B.
    rst_n = 1'b0;
    req_a = 1'b1; req_b = 1'b1; op_a = 1'b1; op_b = 1'b1;
    wdata_a = 8'h11; wdata_b = 8'h22;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(10, who);
      chk("rr_order", who, i[0]);
      chk("rr_no_simul_ack", ack_a && ack_b, 1'b0);
      tick(1);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(3);

    // Rejections: pop on empty, then push on full.
    stk_empty = 1'b1;
    req_a = 1'b1; op_a = 1'b0;
    tick(1);
    chk("empty_no_pop", stk_pop, 1'b0);
    chk("empty_ack", ack_a, 1'b1);
    chk("empty_err", err_a, 1'b1);
    req_a = 1'b0;
    tick(1);
    chk("empty_ack_gone", ack_a, 1'b0);
    stk_empty = 1'b0; stk_full = 1'b1;
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h77;
    tick(1);
    chk("full_no_push", stk_push, 1'b0);
    chk("full_ack", ack_a, 1'b1);
    chk("full_err", err_a, 1'b1);
    req_a = 1'b0;
    tick(1);
    stk_full = 1'b0;
    tick(1);

    // Stack never answers.
    resp_en = 1'b0;
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h33;
    tick(1);
    chk("nodone_push", stk_push, 1'b1);
    req_a = 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
    tick(TO);
    chk("to_not_yet", ack_a, 1'b0);
    tick(1);
    chk("to_ack", ack_a, 1'b1);
    chk("to_err", err_a, 1'b1);
    tick(1);
    req_a = 1'b1;
    tick(1);
    req_a = 1'b0;
    tick(3);
`else
    tick(30);
    chk("nodone_busy_held", busy, 1'b1);
    chk("nodone_no_ack", ack_a, 1'b0);
`endif

    // Reset mid-WAIT: immediate idle, no ack, A has priority afterwards.
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ack", {ack_a, ack_b}, 2'b00);
    chk("midrst_owner", owner, 1'b0);
    chk("midrst_rdata", rdata, 8'h00);
    tick(1);
    rst_n = 1'b1;
    resp_en = 1'b1;
    req_a = 1'b1; req_b = 1'b1; op_a = 1'b1; op_b = 1'b1;
    wait_ack(10, who);
    chk("midrst_first_a", who, 1'b0);
    req_a = 1'b0; req_b = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
